// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;
   typedef enum logic {RUN, MDU_WAIT} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard inputs and register enable/flush controls
interface hazard_ctrl_if;
   logic [hazard_ctrl_pkg::REG_W-1:0] rs_id;
   logic [hazard_ctrl_pkg::REG_W-1:0] rt_id;
   logic [hazard_ctrl_pkg::REG_W-1:0] ex_rt;
   logic id_uses_rt;
   logic jump_id;
   logic ex_mem_read;
   logic branch_taken_ex;
   logic mdu_start_ex;
   logic pc_write;
   logic IF_ID_keep;
   logic if_id_flush;
   logic id_ex_keep;
   logic id_ex_flush;
   logic ex_mem_flush;
   logic mdu_busy;

   modport master (
      output rs_id, rt_id, ex_rt, id_uses_rt, jump_id, ex_mem_read, branch_taken_ex, mdu_start_ex,
      input  pc_write, IF_ID_keep, if_id_flush, id_ex_keep, id_ex_flush, ex_mem_flush, mdu_busy
   );

   modport slave (
      input  rs_id, rt_id, ex_rt, id_uses_rt, jump_id, ex_mem_read, branch_taken_ex, mdu_start_ex,
      output pc_write, IF_ID_keep, if_id_flush, id_ex_keep, id_ex_flush, ex_mem_flush, mdu_busy
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous active-low reset
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, redirect and MULT/DIV stall control for the 5-stage pipeline
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam logic [7:0] CNT_INIT = 8'(MDU_CYCLES - 2);

   state_t     state;
   logic [7:0] cnt;
   logic       load_use;

   assign load_use = hz.ex_mem_read && (hz.ex_rt != REG_ZERO) &&
                     ((hz.ex_rt == hz.rs_id) || (hz.id_uses_rt && (hz.ex_rt == hz.rt_id)));

   // A branch in EX squashes the MULT/DIV decode, so it never enters MDU_WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         case (state)
            RUN: begin
               if (!hz.branch_taken_ex && hz.mdu_start_ex) begin
                  state <= MDU_WAIT;
                  cnt   <= CNT_INIT;
               end
            end
            MDU_WAIT: begin
               if (cnt != 8'd0)
                  cnt <= cnt - 8'd1;
               else
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      hz.pc_write     = 1'b1;
      hz.IF_ID_keep   = 1'b1;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_keep   = 1'b1;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_flush = 1'b0;
      hz.mdu_busy     = (state == MDU_WAIT);
      if (state == RUN) begin
         if (hz.branch_taken_ex) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
         end else if (hz.mdu_start_ex) begin
            hz.pc_write     = 1'b0;
            hz.IF_ID_keep   = 1'b0;
            hz.id_ex_keep   = 1'b0;
            hz.ex_mem_flush = 1'b1;
         end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.IF_ID_keep  = 1'b0;
            hz.id_ex_flush = 1'b1;
         end else if (hz.jump_id) begin
            hz.if_id_flush = 1'b1;
         end
      end else if (cnt != 8'd0) begin
         hz.pc_write     = 1'b0;
         hz.IF_ID_keep   = 1'b0;
         hz.id_ex_keep   = 1'b0;
         hz.ex_mem_flush = 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!hz.pc_write),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized bench for hazard_ctrl against a cycle model
module tb_hazard_ctrl;
   localparam int MDU_CYCLES = 4;
   localparam int CNT_W      = 4;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] stall_cnt;
   int               checks = 0;
   int               errors = 0;

   // Model state: cycles the current MULT/DIV still has left in EX after this one.
   int mdu_left = 0;
   int exp_cnt  = 0;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .hz        (hz.slave),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input int rs, input int rt, input logic uses_rt,
                        input logic jump, input logic mem_read, input int ert,
                        input logic br, input logic mdu);
      logic lu;
      logic e_pc, e_ifk, e_iff, e_idk, e_idf, e_emf, e_busy;
      rst               = r;
      hz.rs_id          = 5'(rs);
      hz.rt_id          = 5'(rt);
      hz.id_uses_rt     = uses_rt;
      hz.jump_id        = jump;
      hz.ex_mem_read    = mem_read;
      hz.ex_rt          = 5'(ert);
      hz.branch_taken_ex = br;
      hz.mdu_start_ex   = mdu;
      lu = mem_read && (ert != 0) && ((ert == rs) || (uses_rt && (ert == rt)));
      e_pc = 1; e_ifk = 1; e_iff = 0; e_idk = 1; e_idf = 0; e_emf = 0;
      e_busy = (mdu_left > 0);
      if (mdu_left > 1) begin
         e_pc = 0; e_ifk = 0; e_idk = 0; e_emf = 1;
      end else if (mdu_left == 0) begin
         if (br) begin
            e_iff = 1; e_idf = 1;
         end else if (mdu) begin
            e_pc = 0; e_ifk = 0; e_idk = 0; e_emf = 1;
         end else if (lu) begin
            e_pc = 0; e_ifk = 0; e_idf = 1;
         end else if (jump) begin
            e_iff = 1;
         end
      end
      @(negedge clk);
      if (r) begin
         check("ctl", {hz.pc_write, hz.IF_ID_keep, hz.if_id_flush, hz.id_ex_keep,
                       hz.id_ex_flush, hz.ex_mem_flush, hz.mdu_busy},
               {e_pc, e_ifk, e_iff, e_idk, e_idf, e_emf, e_busy});
         check("stall_cnt", int'(stall_cnt), exp_cnt);
      end
      @(posedge clk);
      if (!r) begin
         mdu_left = 0;
         exp_cnt  = 0;
      end else begin
         if (!e_pc && exp_cnt < CNT_MAX) exp_cnt++;
         if (mdu_left > 0) mdu_left--;
         else if (mdu && !br) mdu_left = MDU_CYCLES - 1;
      end
      #1;
   endtask

   task automatic idle();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic rr, mdu_in;
      // reset held two cycles with a MULT/DIV present
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      // load-use on rs, then register zero never hazards
      cycle(1, 8, 0, 0, 0, 1, 8, 0, 0);
      idle();
      cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // load-use on rt, and rt ignored when not read
      cycle(1, 3, 9, 1, 0, 1, 9, 0, 0);
      cycle(1, 3, 9, 0, 0, 1, 9, 0, 0);
      // taken branch overrides load-use and jump
      cycle(1, 8, 0, 0, 1, 1, 8, 1, 0);
      // load-use on a jr beats the jump, then plain jump
      cycle(1, 8, 0, 0, 1, 1, 8, 0, 0);
      cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
      // MULT/DIV held for its full occupancy with ignored distractions
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 8, 0, 0, 1, 1, 8, 1, 1);
      cycle(1, 0, 0, 0, 1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();
      // reset in the middle of MDU_WAIT
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      // saturation of the stall counter
      for (int i = 0; i < 20; i++) cycle(1, 8, 0, 0, 0, 1, 8, 0, 0);
      idle();
      check("stall_sat", int'(stall_cnt), CNT_MAX);
      // randomized traffic with small register numbers to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         rr     = ($urandom_range(0, 59) != 0);
         mdu_in = (mdu_left > 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
         cycle(rr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
               ($urandom_range(0, 4) == 0), 1'($urandom), $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0), mdu_in);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
